// File: rtl/mmul_sequencer.sv
// mmul_sequencer: steps register-file reads through the systolic array, flushes the skew, then drains and clears
module mmul_sequencer #(
    parameter int N       = 4,
    parameter int RADDR_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dec_valid_i,
    input  logic [RADDR_W-1:0]   dec_src1_i,
    input  logic [RADDR_W-1:0]   dec_src2_i,
    input  logic                 dec_drain_i,
    input  logic                 dec_we_i,
    input  logic [RADDR_W-1:0]   dec_dest_i,
    output logic                 dec_ready_o,
    output logic                 rf_rd_en_o,
    output logic [RADDR_W-1:0]   rf_rd_a_o,
    output logic [RADDR_W-1:0]   rf_rd_b_o,
    output logic [$clog2(N)-1:0] rf_rd_k_o,
    output logic                 pe_en_o,
    output logic                 pe_clear_o,
    output logic                 drain_en_o,
    output logic [$clog2(N)-1:0] drain_row_o,
    output logic                 rf_wr_en_o,
    output logic [RADDR_W-1:0]   rf_wr_addr_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int KW = $clog2(N);
    localparam int CW = $clog2(2 * N - 1);
    typedef enum logic [2:0] {CLEAR, IDLE, FEED, FLUSH, DRAIN} state_t;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic               drain_q, we_q;
    logic [RADDR_W-1:0] a_q, b_q, dest_q;
    logic               row_last, flush_last;
    assign row_last   = cnt == CW'(N - 1);
    assign flush_last = cnt == CW'(2 * N - 3);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            cnt     <= '0;
            drain_q <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            dest_q  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                IDLE: if (dec_valid_i) begin
                    state   <= FEED;
                    cnt     <= '0;
                    a_q     <= dec_src1_i;
                    b_q     <= dec_src2_i;
                    drain_q <= dec_drain_i;
                    we_q    <= dec_we_i;
                    dest_q  <= dec_dest_i;
                end
                FEED: begin
                    state <= row_last ? FLUSH : FEED;
                    cnt   <= row_last ? '0 : cnt + 1'b1;
                end
                FLUSH: begin
                    state <= flush_last ? (drain_q ? DRAIN : IDLE) : FLUSH;
                    cnt   <= flush_last ? '0 : cnt + 1'b1;
                end
                DRAIN: begin
                    state <= row_last ? CLEAR : DRAIN;
                    cnt   <= row_last ? '0 : cnt + 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end
    assign dec_ready_o  = state == IDLE;
    assign busy_o       = state != IDLE;
    assign rf_rd_en_o   = state == FEED;
    assign rf_rd_k_o    = state == FEED ? cnt[KW-1:0] : '0;
    assign rf_rd_a_o    = a_q;
    assign rf_rd_b_o    = b_q;
    assign pe_en_o      = state == FEED || state == FLUSH;
    assign pe_clear_o   = state == CLEAR;
    assign drain_en_o   = state == DRAIN;
    assign drain_row_o  = state == DRAIN ? cnt[KW-1:0] : '0;
    // we is only honoured while draining, so an illegal non-draining write never reaches the register file
    assign rf_wr_en_o   = state == DRAIN && we_q;
    assign rf_wr_addr_o = dest_q;
    assign done_o       = (state == FLUSH && flush_last && !drain_q) || (state == DRAIN && row_last);
endmodule

// File: tb/tb_mmul_sequencer.sv
// tb_mmul_sequencer: timeline reference model of command phases checked every cycle against the sequencer
module tb_mmul_sequencer;
    localparam int N  = 4;
    localparam int RW = 3;
    localparam int KW = 2;
    localparam int VW = 8 + 3 * RW + 2 * KW;
    logic clk = 0, rst = 1, dec_valid = 0, dec_drain = 0, dec_we = 0;
    logic [RW-1:0] dec_src1 = 0, dec_src2 = 0, dec_dest = 0;
    logic dec_ready, rf_rd_en, pe_en, pe_clear, drain_en, rf_wr_en, busy, done;
    logic [RW-1:0] rf_rd_a, rf_rd_b, rf_wr_addr;
    logic [KW-1:0] rf_rd_k, drain_row;
    int errors = 0, checks = 0;
    logic [RW-1:0] m_a = 0, m_b = 0, m_d = 0;

    mmul_sequencer #(.N(N), .RADDR_W(RW)) dut (
        .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid), .dec_src1_i(dec_src1),
        .dec_src2_i(dec_src2), .dec_drain_i(dec_drain), .dec_we_i(dec_we), .dec_dest_i(dec_dest),
        .dec_ready_o(dec_ready), .rf_rd_en_o(rf_rd_en), .rf_rd_a_o(rf_rd_a), .rf_rd_b_o(rf_rd_b),
        .rf_rd_k_o(rf_rd_k), .pe_en_o(pe_en), .pe_clear_o(pe_clear), .drain_en_o(drain_en),
        .drain_row_o(drain_row), .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wr_addr),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] observe();
        return {dec_ready, rf_rd_en, rf_rd_a, rf_rd_b, rf_rd_k, pe_en, pe_clear,
                drain_en, drain_row, rf_wr_en, rf_wr_addr, busy, done};
    endfunction

    // ph: 0 = idle, -1 = clear/reset, 1.. = cycles since acceptance
    function automatic logic [VW-1:0] model(input int ph, input bit dr, input bit w);
        bit ready, clr, feed, flush, drn, fin;
        logic [KW-1:0] k, row;
        if (dr && ph == 4 * N - 1) ph = -1;
        ready = ph == 0;
        clr   = ph == -1;
        feed  = ph >= 1 && ph <= N;
        flush = ph > N && ph <= 3 * N - 2;
        drn   = dr && ph >= 3 * N - 1 && ph <= 4 * N - 2;
        k     = feed ? KW'(ph - 1) : '0;
        row   = drn ? KW'(ph - (3 * N - 1)) : '0;
        fin   = (!dr && ph == 3 * N - 2) || (dr && ph == 4 * N - 2);
        return {ready, feed, m_a, m_b, k, feed | flush, clr, drn, row, drn & w, m_d, !ready, fin};
    endfunction

    function automatic int cmd_len(input bit dr);
        return dr ? 4 * N - 1 : 3 * N - 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [RW-1:0] a, b, input bit dr, w, input logic [RW-1:0] d);
        dec_valid = 1; dec_src1 = a; dec_src2 = b; dec_drain = dr; dec_we = w; dec_dest = d;
        m_a = a; m_b = b; m_d = d;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (observe() !== model(-1, 0, 0)) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, observe(), model(-1, 0, 0));
            end
        end
        rst = 0;
        checks++;
        if (observe() !== model(-1, 0, 0)) begin
            errors++;
            $display("FAIL reset_clear got=%h exp=%h", observe(), model(-1, 0, 0));
        end
        tick();
        checks++;
        if (observe() !== model(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=%h", observe(), model(0, 0, 0));
        end
    endtask

    task automatic test_mmul_d();
        int wr_cnt = 0, pe_cnt = 0;
        issue(1, 2, 1, 1, 5);
        for (int p = 1; p <= cmd_len(1); p++) begin
            tick();
            dec_valid = 0;
            wr_cnt += int'(rf_wr_en);
            pe_cnt += int'(pe_en);
            checks++;
            if (observe() !== model(p, 1, 1)) begin
                errors++;
                $display("FAIL mmul_d p=%0d got=%h exp=%h", p, observe(), model(p, 1, 1));
            end
        end
        tick();
        checks++;
        if (observe() !== model(0, 1, 1)) begin
            errors++;
            $display("FAIL mmul_d_idle got=%h exp=%h", observe(), model(0, 1, 1));
        end
        checks++;
        if (wr_cnt !== 4 || pe_cnt !== 10) begin
            errors++;
            $display("FAIL mmul_d_counts wr=%0d pe=%0d exp wr=4 pe=10", wr_cnt, pe_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int clr_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            bit dr = c == 2;
            issue(RW'(c + 3), RW'(c + 4), dr, dr, RW'(c + 1));
            for (int p = 1; p <= cmd_len(dr); p++) begin
                tick();
                if (dr) dec_valid = 0;
                clr_cnt += int'(pe_clear);
                checks++;
                if (observe() !== model(p, dr, dr)) begin
                    errors++;
                    $display("FAIL b2b cmd=%0d p=%0d got=%h exp=%h", c, p, observe(), model(p, dr, dr));
                end
            end
            tick();
            checks++;
            if (observe() !== model(0, dr, dr)) begin
                errors++;
                $display("FAIL b2b_idle cmd=%0d got=%h exp=%h", c, observe(), model(0, dr, dr));
            end
        end
        checks++;
        if (clr_cnt !== 1) begin
            errors++;
            $display("FAIL b2b_clear_count got=%0d exp=1", clr_cnt);
        end
    endtask

    task automatic test_drain_variants();
        for (int c = 0; c < 2; c++) begin
            bit dr = c == 0;
            int den = 0, wr = 0;
            issue(2, 3, dr, !dr, 6);
            for (int p = 1; p <= cmd_len(dr); p++) begin
                tick();
                dec_valid = 0;
                den += int'(drain_en);
                wr += int'(rf_wr_en);
                checks++;
                if (observe() !== model(p, dr, !dr)) begin
                    errors++;
                    $display("FAIL drain_var dr=%0d p=%0d got=%h exp=%h", dr, p, observe(), model(p, dr, !dr));
                end
            end
            tick();
            checks++;
            if (den !== (dr ? 4 : 0) || wr !== 0) begin
                errors++;
                $display("FAIL drain_var_counts dr=%0d drain=%0d wr=%0d exp drain=%0d wr=0", dr, den, wr, dr ? 4 : 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(4, 5, 1, 1, 2);
        for (int p = 1; p <= N + 3; p++) begin
            tick();
            dec_valid = 0;
            checks++;
            if (observe() !== model(p, 1, 1)) begin
                errors++;
                $display("FAIL rst_mid p=%0d got=%h exp=%h", p, observe(), model(p, 1, 1));
            end
        end
        rst = 1;
        m_a = 0; m_b = 0; m_d = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (observe() !== model(-1, 0, 0)) begin
                errors++;
                $display("FAIL rst_mid_hold cyc=%0d got=%h exp=%h", i, observe(), model(-1, 0, 0));
            end
        end
        rst = 0;
        tick();
        checks++;
        if (observe() !== model(0, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_idle got=%h exp=%h", observe(), model(0, 0, 0));
        end
    endtask

    task automatic test_input_toggle();
        issue(6, 7, 1, 1, 4);
        for (int p = 1; p <= cmd_len(1); p++) begin
            tick();
            checks++;
            if (observe() !== model(p, 1, 1)) begin
                errors++;
                $display("FAIL toggle p=%0d got=%h exp=%h", p, observe(), model(p, 1, 1));
            end
            dec_valid = p < N ? 1'($urandom) : 1'b0;
            dec_src1 = RW'($urandom); dec_src2 = RW'($urandom); dec_dest = RW'($urandom);
            dec_drain = 1'($urandom); dec_we = 1'($urandom);
        end
        tick();
        checks++;
        if (rf_rd_a !== 3'd6 || rf_rd_b !== 3'd7 || rf_wr_addr !== 3'd4 || dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL toggle_latched a=%0d b=%0d d=%0d rdy=%b exp 6 7 4 1", rf_rd_a, rf_rd_b, rf_wr_addr, dec_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 8; c++) begin
            bit dr = 1'($urandom), w = 1'($urandom);
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++;
                if (observe() !== model(0, 0, 0)) begin
                    errors++;
                    $display("FAIL rand_gap cmd=%0d got=%h exp=%h", c, observe(), model(0, 0, 0));
                end
            end
            issue(RW'($urandom), RW'($urandom), dr, w, RW'($urandom));
            for (int p = 1; p <= cmd_len(dr); p++) begin
                tick();
                dec_valid = 0;
                checks++;
                if (observe() !== model(p, dr, w)) begin
                    errors++;
                    $display("FAIL rand cmd=%0d p=%0d got=%h exp=%h", c, p, observe(), model(p, dr, w));
                end
            end
            tick();
            checks++;
            if (observe() !== model(0, dr, w)) begin
                errors++;
                $display("FAIL rand_idle cmd=%0d got=%h exp=%h", c, observe(), model(0, dr, w));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mmul_d();
        test_back_to_back();
        test_drain_variants();
        test_reset_mid();
        test_input_toggle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
